// File: rtl/led_fade_pwm_if.sv
// Blink-level / LED-drive bundle between the blink generator and the fade stage.
// The master drives blink level and mode; the slave returns PWM drive, brightness and ramp status.
interface led_fade_pwm_if #(
  parameter int PWM_BITS = 8
);
  logic                blink_in;
  logic                enable;
  logic                led_out;
  logic [PWM_BITS-1:0] level;
  logic                busy;

  modport master (
    output blink_in,
    output enable,
    input  led_out,
    input  level,
    input  busy
  );

  modport slave (
    input  blink_in,
    input  enable,
    output led_out,
    output level,
    output busy
  );
endinterface

// File: rtl/led_fade_pwm.sv
// LED fader: turns blink edges into linear brightness ramps and drives the LED pin with PWM.
// enable=0 bypasses the ramps and snaps brightness straight to the blink target.
module led_fade_pwm #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 2031
) (
  input  logic           clk,
  input  logic           reset_n,
  led_fade_pwm_if.slave  bus
);

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PRE_W-1:0]    PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0]    PRE_TC   = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] RAMP_UP   = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] RAMP_DOWN = 2'd3;

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [PWM_BITS-1:0] level_r;
  logic [PWM_BITS-1:0] level_nxt_s;
  logic [PRE_W-1:0]    presc_r;
  logic [PRE_W-1:0]    presc_nxt_s;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic                led_out_r;
  logic                busy_r;
  logic                tc_s;

  assign tc_s = (presc_r == PRE_TC);

  // Next state, level and prescaler; the prescaler defaults to cleared on every transition.
  always_comb begin
    state_nxt_s = state_r;
    level_nxt_s = level_r;
    presc_nxt_s = PRE_ZERO;
    if (!bus.enable) begin
      if (bus.blink_in) begin
        state_nxt_s = IDLE_HIGH;
        level_nxt_s = LVL_MAX;
      end else begin
        state_nxt_s = IDLE_LOW;
        level_nxt_s = LVL_ZERO;
      end
    end else begin
      case (state_r)
        IDLE_LOW: begin
          if (bus.blink_in) state_nxt_s = RAMP_UP;
          else              state_nxt_s = IDLE_LOW;
        end
        RAMP_UP: begin
          // A reversal outranks a coincident step: level holds for that cycle.
          if (!bus.blink_in) begin
            state_nxt_s = RAMP_DOWN;
          end else if (tc_s) begin
            if (level_r != LVL_MAX) level_nxt_s = level_r + LVL_ONE;
            else                    level_nxt_s = level_r;
            if (level_r >= LVL_LAST) state_nxt_s = IDLE_HIGH;
            else                     state_nxt_s = RAMP_UP;
          end else begin
            presc_nxt_s = presc_r + PRE_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!bus.blink_in) state_nxt_s = RAMP_DOWN;
          else               state_nxt_s = IDLE_HIGH;
        end
        RAMP_DOWN: begin
          if (bus.blink_in) begin
            state_nxt_s = RAMP_UP;
          end else if (tc_s) begin
            if (level_r != LVL_ZERO) level_nxt_s = level_r - LVL_ONE;
            else                     level_nxt_s = level_r;
            if (level_r <= LVL_ONE) state_nxt_s = IDLE_LOW;
            else                    state_nxt_s = RAMP_DOWN;
          end else begin
            presc_nxt_s = presc_r + PRE_ONE;
          end
        end
        default: begin
          state_nxt_s = IDLE_LOW;
          level_nxt_s = LVL_ZERO;
        end
      endcase
    end
  end

  // Fade state registers; busy is registered from the next state so it tracks the state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE_LOW;
      level_r <= LVL_ZERO;
      presc_r <= PRE_ZERO;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      level_r <= level_nxt_s;
      presc_r <= presc_nxt_s;
      busy_r  <= (state_nxt_s == RAMP_UP) || (state_nxt_s == RAMP_DOWN);
    end
  end

  // Free-running PWM counter with period MAX, so MAX gives a solid-on output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_r <= LVL_ZERO;
      led_out_r <= 1'b0;
    end else begin
      if (pwm_cnt_r == LVL_LAST) pwm_cnt_r <= LVL_ZERO;
      else                       pwm_cnt_r <= pwm_cnt_r + LVL_ONE;
      led_out_r <= (pwm_cnt_r < level_r);
    end
  end

  assign bus.level   = level_r;
  assign bus.busy    = busy_r;
  assign bus.led_out = led_out_r;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm: directed vector table, random run against a
// ramp-level reference model, and a PWM duty window on a slow-step instance.
module tb_led_fade_pwm;

  localparam int MAXV   = 15;
  localparam int STEP_A = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  led_fade_pwm_if #(.PWM_BITS(4)) a_if();
  led_fade_pwm_if #(.PWM_BITS(4)) b_if();

  led_fade_pwm #(.PWM_BITS(4), .STEP_DIV(STEP_A)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (a_if)
  );

  led_fade_pwm #(.PWM_BITS(4), .STEP_DIV(1000)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit b;
    bit e;
    int n;
    int lvl;
    bit bsy;
  } vec_t;

  vec_t vt[$];

  // reference model: brightness, ramp activity, cycles since last step, PWM phase
  int m_level;
  int m_timer;
  int m_pwm;
  bit m_led;
  bit m_ramp;
  bit m_prev;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_level = 0;
    m_timer = 0;
    m_pwm   = 0;
    m_led   = 1'b0;
    m_ramp  = 1'b0;
    m_prev  = 1'b0;
  endfunction

  function automatic void model_edge(input bit b, input bit e);
    int tgt;
    tgt   = b ? MAXV : 0;
    m_led = (m_pwm < m_level);
    m_pwm = (m_pwm + 1) % MAXV;
    if (!e) begin
      m_level = tgt;
      m_ramp  = 1'b0;
      m_timer = 0;
    end else if (b != m_prev) begin
      m_ramp  = 1'b1;
      m_timer = 0;
    end else if (m_ramp) begin
      m_timer++;
      if (m_timer == STEP_A) begin
        m_timer = 0;
        if (m_level < tgt)      m_level++;
        else if (m_level > tgt) m_level--;
        if (m_level == tgt) m_ramp = 1'b0;
      end
    end
    m_prev = b;
  endfunction

  task automatic tick(input bit full);
    bit b;
    bit e;
    b = a_if.blink_in;
    e = a_if.enable;
    @(posedge clk);
    model_edge(b, e);
    #1;
    check("led_out", int'(a_if.led_out), int'(m_led));
    if (full) begin
      check("level", int'(a_if.level), m_level);
      check("busy", int'(a_if.busy), int'(m_ramp));
    end
  endtask

  initial begin
    int highs;
    bit exp_led;

    // fade in, idle high, fade out
    vt.push_back(vec_t'{1'b0, 1'b1,  2,  0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1,  1,  0, 1'b1});
    vt.push_back(vec_t'{1'b1, 1'b1,  2,  0, 1'b1});
    vt.push_back(vec_t'{1'b1, 1'b1,  1,  1, 1'b1});
    vt.push_back(vec_t'{1'b1, 1'b1, 41, 14, 1'b1});
    vt.push_back(vec_t'{1'b1, 1'b1,  1, 15, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1,  4, 15, 1'b0});
    vt.push_back(vec_t'{1'b0, 1'b1,  1, 15, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b1,  3, 14, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b1, 42,  0, 1'b0});
    // reversal at level 7 coinciding with a step edge
    vt.push_back(vec_t'{1'b1, 1'b1,  1,  0, 1'b1});
    vt.push_back(vec_t'{1'b1, 1'b1, 22,  7, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b1,  1,  7, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b1,  2,  7, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b1,  1,  6, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b1, 17,  1, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b1,  1,  0, 1'b0});
    // bypass mid-ramp at level 9, enable toggling in idle high
    vt.push_back(vec_t'{1'b1, 1'b1,  1,  0, 1'b1});
    vt.push_back(vec_t'{1'b1, 1'b1, 27,  9, 1'b1});
    vt.push_back(vec_t'{1'b1, 1'b0,  1, 15, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0,  3, 15, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1,  5, 15, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0,  2, 15, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1,  3, 15, 1'b0});
    vt.push_back(vec_t'{1'b0, 1'b0,  1,  0, 1'b0});
    vt.push_back(vec_t'{1'b0, 1'b1,  3,  0, 1'b0});
    // reversal at level 0: ramp down with inhibited decrement, exits on the step edge
    vt.push_back(vec_t'{1'b1, 1'b1,  1,  0, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b1,  1,  0, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b1,  2,  0, 1'b1});
    vt.push_back(vec_t'{1'b0, 1'b1,  1,  0, 1'b0});

    reset_n     = 1'b0;
    a_if.blink_in = 1'b0;
    a_if.enable   = 1'b1;
    b_if.blink_in = 1'b0;
    b_if.enable   = 1'b1;
    model_reset();

    // reset before any clock edge
    #2;
    check("rst_level", int'(a_if.level), 0);
    check("rst_busy", int'(a_if.busy), 0);
    check("rst_led", int'(a_if.led_out), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    foreach (vt[i]) begin
      a_if.blink_in = vt[i].b;
      a_if.enable   = vt[i].e;
      repeat (vt[i].n) tick(1'b0);
      check($sformatf("vec%0d_level", i), int'(a_if.level), vt[i].lvl);
      check($sformatf("vec%0d_busy", i), int'(a_if.busy), int'(vt[i].bsy));
    end

    // asynchronous reset in the middle of a ramp
    a_if.blink_in = 1'b1;
    repeat (19) tick(1'b0);
    check("pre_rst_level", int'(a_if.level), 6);
    check("pre_rst_busy", int'(a_if.busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_level", int'(a_if.level), 0);
    check("async_rst_busy", int'(a_if.busy), 0);
    check("async_rst_led", int'(a_if.led_out), 0);
    model_reset();
    a_if.blink_in = 1'b0;
    reset_n = 1'b1;

    // random blink/enable against the reference model
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) a_if.blink_in = ~a_if.blink_in;
      if ($urandom_range(0, a_if.enable ? 79 : 5) == 0) a_if.enable = ~a_if.enable;
      tick(1'b1);
    end

    // PWM duty window at level 5 on the slow-step instance
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    b_if.blink_in = 1'b1;
    b_if.enable   = 1'b1;
    highs = 0;
    for (int k = 1; k <= 5024; k++) begin
      @(posedge clk);
      #1;
      if (k == 5000) check("b_level_4", int'(b_if.level), 4);
      if (k == 5001) begin
        check("b_level_5", int'(b_if.level), 5);
        check("b_busy", int'(b_if.busy), 1);
      end
      if (k >= 5010) begin
        exp_led = (((k - 1) % MAXV) < 5);
        check($sformatf("b_led_k%0d", k), int'(b_if.led_out), int'(exp_led));
        if (b_if.led_out) highs++;
      end
    end
    check("b_duty_high", highs, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Downstream stage of the 2 Hz blink generator: consumes its one-bit blink level and drives the board LED with a PWM signal. The blink edges are turned into linear brightness ramps (fade in, fade out) instead of hard on/off steps. The block sits between the blink counter and the LED pin and runs on the same internal-oscillator clock.

## Interface

Parameters:
- `PWM_BITS`, default 8: brightness resolution. `MAX = 2^PWM_BITS - 1`. Legal range 2..12.
- `STEP_DIV`, default 2031: clock cycles per one-LSB brightness step. Legal minimum is 1. The default gives a full ramp of about 0.25 s at 2.08 MHz.

Ports:
- `clk` input, 1 bit: internal oscillator clock. All logic is on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `blink_in` input, 1 bit: blink level from the upstream stage, synchronous to `clk`. 1 means target `MAX`, 0 means target 0.
- `enable` input, 1 bit: 1 selects fade mode. 0 selects bypass, where brightness snaps directly to the target.
- `led_out` output, 1 bit: registered PWM drive to the LED pin.
- `level` output, `PWM_BITS` bits: current brightness.
- `busy` output, 1 bit: high while a ramp is in progress.

## Operation

State machine: `IDLE_LOW`, `RAMP_UP`, `IDLE_HIGH`, `RAMP_DOWN`.
- `IDLE_LOW`: `level` = 0. If `blink_in`=1 and `enable`=1, go to `RAMP_UP`.
- `RAMP_UP`:
  - On each prescaler terminal count, `level` += 1.
  - If the increment makes `level` = `MAX`, go to `IDLE_HIGH`.
  - If `blink_in`=0, go to `RAMP_DOWN` starting from the current `level`. No step is taken in that cycle.
- `IDLE_HIGH` and `RAMP_DOWN` are the mirror images of the two states above: decrement, exit to `IDLE_LOW` at 0.
- Simultaneous terminal count and reversal of `blink_in`: the reversal wins, and `level` is unchanged in that cycle.

Prescaler:
- Width is `max(1, $clog2(STEP_DIV))`. It counts 0..`STEP_DIV`-1 and only runs in the ramp states.
- It is cleared to 0 on every state transition and whenever a ramp state is not active.
- Terminal count is `STEP_DIV`-1. With `STEP_DIV`=1, every ramp cycle is a step.

Level arithmetic:
- Saturating, never wraps.
- Increment is inhibited at `MAX` and decrement is inhibited at 0. In a correct design these cases are unreachable, but the guard is required.

PWM:
- `pwm_cnt` is free-running and counts 0..`MAX`-1 (period `MAX` cycles), wrapping to 0.
- `led_out` is registered from (`pwm_cnt` < `level`).
- At `level` 0, `led_out` is constantly 0. At `MAX`, it is constantly 1.

Bypass (`enable`=0):
- The state is forced to `IDLE_HIGH` if `blink_in`=1, otherwise to `IDLE_LOW`.
- `level` is loaded with `MAX` or 0 accordingly, the prescaler is cleared, and `busy` = 0.
- This overrides any ramp in progress.
- When `enable` returns to 1, ramps resume from the idle state.

`busy` is 1 exactly when the state is `RAMP_UP` or `RAMP_DOWN`.

Reset (`reset_n`=0):
- Asynchronous.
- State `IDLE_LOW`; `level`, prescaler, `pwm_cnt` = 0; `led_out` = 0; `busy` = 0.
- Reset asserted mid-ramp aborts the ramp immediately, without waiting for a clock edge.
- Release is synchronous to the next rising `clk`.

## Timing

- A change on `blink_in` is sampled at edge N. The state and `busy` change at edge N.
- The first `level` step occurs at edge N+`STEP_DIV`. Step k occurs at edge N+k·`STEP_DIV`.
- A full ramp from 0 to `MAX` takes `MAX`·`STEP_DIV` cycles after entry. `busy` drops in the same edge that `level` reaches the end value.
- `led_out` lags `level`/`pwm_cnt` by one cycle because of its output register.
- Bypass: `level` updates at the first edge after `enable`=0 or after a `blink_in` change.

## Test plan

All scenarios except 5 use `PWM_BITS`=4 (`MAX`=15) and `STEP_DIV`=3.

1. **Reset.**
   - Pulse `reset_n` low with no clock → `led_out`=0, `level`=0, `busy`=0.
   - Assert `reset_n` while `level`=6 in `RAMP_UP` → all outputs 0 immediately, before any clock edge.
2. **Fade in.** `enable`=1, `blink_in` 0→1 sampled at edge N → `busy`=1 from N; `level`=1 at N+3; `level`=15 and `busy`=0 at N+45; then `led_out`=1 on every cycle.
3. **Reversal mid-ramp.** While in `RAMP_UP` at `level`=7, drive `blink_in`=0 → state `RAMP_DOWN`, no step that cycle; `level`=6 three cycles later; `level`=0 and `busy`=0 twenty-one cycles after the reversal.
4. **Bypass.**
   - `enable`=0 with `level`=9 mid-ramp and `blink_in`=1 → `level`=15 and `busy`=0 at the next edge; `led_out`=1 continuously one cycle later.
   - `blink_in`→0 → `level`=0 at the next edge.
5. **PWM duty.** `PWM_BITS`=4, `STEP_DIV`=1000. Hold mid-ramp at `level`=5 → `led_out` high for exactly 5 of every 15 consecutive cycles, aligned to the `pwm_cnt` wrap.
6. **Saturation and idle stability.** In `IDLE_HIGH`, toggle `enable` 1→0→1 with `blink_in`=1 held → `level` stays 15 and `busy` stays 0; no wrap to 0.
